// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC and the imem req/ack port.
// Holds a returned instruction under decode stall; arbitrates redirects.
module fetch_ctrl #(
  parameter int unsigned PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(32'h0000_0080)
) (
  input  logic                fc_clk,
  input  logic                fc_rst,
  input  logic                fc_i_stall,
  input  logic                fc_i_exc,
  input  logic                fc_i_br_taken,
  input  logic [PC_WIDTH-1:0] fc_i_br_target,
  input  logic                fc_i_jmp,
  input  logic [PC_WIDTH-1:0] fc_i_jmp_target,
  output logic                fc_o_imem_req,
  output logic [PC_WIDTH-1:0] fc_o_imem_addr,
  input  logic                fc_i_imem_ack,
  input  logic [31:0]         fc_i_imem_data,
  output logic                fc_o_if_valid,
  output logic [PC_WIDTH-1:0] fc_o_if_pc,
  output logic [31:0]         fc_o_if_instr,
  output logic                fc_o_flush_if_id,
  output logic                fc_o_flush_id_ex
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HELD
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                kill_q, kill_d;
  logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]         hold_instr_q, hold_instr_d;
  logic                req_q, req_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                vld_q, vld_d;
  logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [31:0]         if_instr_q, if_instr_d;

  logic                redirect;
  logic [PC_WIDTH-1:0] raw_target;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] issue_addr;
  logic                issue;

  // Redirect arbitration: exception beats branch beats jump.
  always_comb begin
    redirect   = fc_i_exc | fc_i_br_taken | fc_i_jmp;
    raw_target = fc_i_jmp_target;
    if (fc_i_exc)
      raw_target = EXC_VECTOR;
    else if (fc_i_br_taken)
      raw_target = fc_i_br_target;
    target = {raw_target[PC_WIDTH-1:2], 2'b00};
  end

  assign fc_o_flush_if_id = redirect & ~fc_rst;
  assign fc_o_flush_id_ex = (fc_i_exc | fc_i_br_taken) & ~fc_rst;

  // Next-state and datapath updates for the fetch sequencer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    req_d        = req_q;
    addr_d       = addr_q;
    vld_d        = 1'b0;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    issue        = 1'b0;
    issue_addr   = pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          issue      = 1'b1;
          issue_addr = target;
        end else if (!fc_i_stall) begin
          issue = 1'b1;
        end
      end
      BUSY: begin
        if (fc_i_imem_ack) begin
          if (redirect || kill_q) begin
            issue      = 1'b1;
            issue_addr = redirect ? target : pc_q;
            kill_d     = 1'b0;
          end else if (fc_i_stall) begin
            hold_pc_d    = addr_q;
            hold_instr_d = fc_i_imem_data;
            req_d        = 1'b0;
            state_d      = HELD;
          end else begin
            vld_d      = 1'b1;
            if_pc_d    = addr_q;
            if_instr_d = fc_i_imem_data;
            issue      = 1'b1;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = target;
        end
      end
      HELD: begin
        if (redirect) begin
          issue        = 1'b1;
          issue_addr   = target;
          hold_pc_d    = '0;
          hold_instr_d = '0;
        end else if (!fc_i_stall) begin
          vld_d      = 1'b1;
          if_pc_d    = hold_pc_q;
          if_instr_d = hold_instr_q;
          issue      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      req_d   = 1'b1;
      addr_d  = issue_addr;
      pc_d    = issue_addr + PC_WIDTH'(4);
      state_d = BUSY;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge fc_clk) begin
    if (fc_rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VECTOR;
      kill_q       <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      req_q        <= 1'b0;
      addr_q       <= RESET_VECTOR;
      vld_q        <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      vld_q        <= vld_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

  assign fc_o_imem_req  = req_q;
  assign fc_o_imem_addr = addr_q;
  assign fc_o_if_valid  = vld_q;
  assign fc_o_if_pc     = if_pc_q;
  assign fc_o_if_instr  = if_instr_q;

endmodule
